// File: rtl/regfile_wb_arbiter.sv
// Four-lane writeback arbiter feeding a two-write-port register file.
// Each lane buffers two requests; heads are granted round-robin.
module regfile_wb_arbiter #(
    parameter int SRAM_DEPTH = 16,
    parameter int SRAM_INDEX = 4,
    parameter int SRAM_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  lane0_valid_i,
    input  logic [SRAM_INDEX-1:0] lane0_addr_i,
    input  logic [SRAM_WIDTH-1:0] lane0_data_i,
    output logic                  lane0_ready_o,
    input  logic                  lane1_valid_i,
    input  logic [SRAM_INDEX-1:0] lane1_addr_i,
    input  logic [SRAM_WIDTH-1:0] lane1_data_i,
    output logic                  lane1_ready_o,
    input  logic                  lane2_valid_i,
    input  logic [SRAM_INDEX-1:0] lane2_addr_i,
    input  logic [SRAM_WIDTH-1:0] lane2_data_i,
    output logic                  lane2_ready_o,
    input  logic                  lane3_valid_i,
    input  logic [SRAM_INDEX-1:0] lane3_addr_i,
    input  logic [SRAM_WIDTH-1:0] lane3_data_i,
    output logic                  lane3_ready_o,
    output logic                  we0_o,
    output logic [SRAM_INDEX-1:0] addr0wr_o,
    output logic [SRAM_WIDTH-1:0] data0wr_o,
    output logic                  we1_o,
    output logic [SRAM_INDEX-1:0] addr1wr_o,
    output logic [SRAM_WIDTH-1:0] data1wr_o,
    output logic                  idle_o
);

    if (SRAM_DEPTH > (1 << SRAM_INDEX)) begin : g_depth_chk
        $error("SRAM_DEPTH exceeds SRAM_INDEX address range");
    end

    logic [3:0]            v_in;
    logic [SRAM_INDEX-1:0] a_in [4];
    logic [SRAM_WIDTH-1:0] d_in [4];

    logic [3:0]            rdy;
    logic [3:0]            push;
    logic [3:0]            pop;
    logic [1:0]            cnt [4];
    logic [3:0]            rd_ptr;
    logic [3:0]            wr_ptr;
    logic [SRAM_INDEX-1:0] fa [4][2];
    logic [SRAM_WIDTH-1:0] fd [4][2];
    logic [SRAM_INDEX-1:0] ha [4];
    logic [SRAM_WIDTH-1:0] hd [4];

    logic [1:0] rr_ptr;
    logic       g0;
    logic       g1;
    logic [1:0] l0;
    logic [1:0] l1;
    logic [1:0] last;
    logic [1:0] lane;

    assign v_in = {lane3_valid_i, lane2_valid_i,
                   lane1_valid_i, lane0_valid_i};
    assign a_in[0] = lane0_addr_i;
    assign a_in[1] = lane1_addr_i;
    assign a_in[2] = lane2_addr_i;
    assign a_in[3] = lane3_addr_i;
    assign d_in[0] = lane0_data_i;
    assign d_in[1] = lane1_data_i;
    assign d_in[2] = lane2_data_i;
    assign d_in[3] = lane3_data_i;

    assign lane0_ready_o = rdy[0];
    assign lane1_ready_o = rdy[1];
    assign lane2_ready_o = rdy[2];
    assign lane3_ready_o = rdy[3];

    assign idle_o = (cnt[0] == 2'd0) && (cnt[1] == 2'd0) &&
                    (cnt[2] == 2'd0) && (cnt[3] == 2'd0) &&
                    !we0_o && !we1_o;

    // Readiness from registered occupancy only; heads of each FIFO
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            rdy[i]  = !reset && (cnt[i] < 2'd2);
            push[i] = v_in[i] && rdy[i];
            ha[i]   = fa[i][rd_ptr[i]];
            hd[i]   = fd[i][rd_ptr[i]];
        end
    end

    // Round-robin scan: up to two grants, second must differ in address
    always_comb begin
        g0   = 1'b0;
        g1   = 1'b0;
        l0   = '0;
        l1   = '0;
        last = rr_ptr;
        lane = '0;
        pop  = '0;
        for (int k = 0; k < 4; k++) begin
            lane = rr_ptr + 2'(k);
            if (cnt[lane] != 2'd0) begin
                if (!g0) begin
                    g0        = 1'b1;
                    l0        = lane;
                    last      = lane;
                    pop[lane] = 1'b1;
                end else if (!g1 && (ha[lane] != ha[l0])) begin
                    g1        = 1'b1;
                    l1        = lane;
                    last      = lane;
                    pop[lane] = 1'b1;
                end
            end
        end
    end

    // FIFO bookkeeping, registered write ports and round-robin pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            rr_ptr    <= '0;
            we0_o     <= 1'b0;
            addr0wr_o <= '0;
            data0wr_o <= '0;
            we1_o     <= 1'b0;
            addr1wr_o <= '0;
            data1wr_o <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (push[i]) begin
                    wr_ptr[i] <= ~wr_ptr[i];
                end
                if (pop[i]) begin
                    rd_ptr[i] <= ~rd_ptr[i];
                end
                cnt[i] <= cnt[i] + {1'b0, push[i]} - {1'b0, pop[i]};
            end
            we0_o     <= g0;
            addr0wr_o <= g0 ? ha[l0] : '0;
            data0wr_o <= g0 ? hd[l0] : '0;
            we1_o     <= g1;
            addr1wr_o <= g1 ? ha[l1] : '0;
            data1wr_o <= g1 ? hd[l1] : '0;
            if (g0) begin
                rr_ptr <= last + 2'd1;
            end
        end
    end

    // Entry storage; push is already blocked while reset is high
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (push[i]) begin
                fa[i][wr_ptr[i]] <= a_in[i];
                fd[i][wr_ptr[i]] <= d_in[i];
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter.
// A queue-based lane model predicts every cycle's write-port outputs.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        vin [4];
    logic [3:0]  ain [4];
    logic [31:0] din [4];
    wire  [3:0]  rdy;
    wire         we0, we1, idle;
    wire  [3:0]  a0, a1;
    wire  [31:0] d0, d1;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0]  a;
        logic [31:0] d;
    } ent_t;

    typedef struct packed {
        logic        we0;
        logic [3:0]  a0;
        logic [31:0] d0;
        logic        we1;
        logic [3:0]  a1;
        logic [31:0] d1;
        logic        idle;
    } exp_t;

    ent_t lq [4][$];
    exp_t exp_q [$];
    int   rr = 0;
    int   acc_cnt [4];

    always #5 clk = ~clk;

    regfile_wb_arbiter dut (
        .clk(clk),
        .reset(rst),
        .lane0_valid_i(vin[0]),
        .lane0_addr_i(ain[0]),
        .lane0_data_i(din[0]),
        .lane0_ready_o(rdy[0]),
        .lane1_valid_i(vin[1]),
        .lane1_addr_i(ain[1]),
        .lane1_data_i(din[1]),
        .lane1_ready_o(rdy[1]),
        .lane2_valid_i(vin[2]),
        .lane2_addr_i(ain[2]),
        .lane2_data_i(din[2]),
        .lane2_ready_o(rdy[2]),
        .lane3_valid_i(vin[3]),
        .lane3_addr_i(ain[3]),
        .lane3_data_i(din[3]),
        .lane3_ready_o(rdy[3]),
        .we0_o(we0),
        .addr0wr_o(a0),
        .data0wr_o(d0),
        .we1_o(we1),
        .addr1wr_o(a1),
        .data1wr_o(d1),
        .idle_o(idle)
    );

    function automatic void chk(string nm, logic [31:0] act,
                                logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t",
                     nm, act, want, $time);
        end
    endfunction

    // Reference: per-lane queues, round-robin over non-empty heads
    task automatic model_edge();
        exp_t e;
        bit   acc [4];
        int   n, g0l, g1l, l;
        e   = '0;
        n   = 0;
        g0l = 0;
        g1l = 0;
        if (rst) begin
            for (int i = 0; i < 4; i++) lq[i].delete();
            rr     = 0;
            e.idle = 1'b1;
        end else begin
            for (int i = 0; i < 4; i++)
                acc[i] = vin[i] && (lq[i].size() < 2);
            for (int k = 0; k < 4; k++) begin
                l = (rr + k) % 4;
                if (lq[l].size() > 0) begin
                    if (n == 0) begin
                        g0l = l;
                        n   = 1;
                    end else if (n == 1 && lq[l][0].a != lq[g0l][0].a) begin
                        g1l = l;
                        n   = 2;
                    end
                end
            end
            if (n >= 1) begin
                e.we0 = 1'b1;
                e.a0  = lq[g0l][0].a;
                e.d0  = lq[g0l][0].d;
            end
            if (n == 2) begin
                e.we1 = 1'b1;
                e.a1  = lq[g1l][0].a;
                e.d1  = lq[g1l][0].d;
            end
            if (n >= 1) void'(lq[g0l].pop_front());
            if (n == 2) void'(lq[g1l].pop_front());
            if (n == 1) rr = (g0l + 1) % 4;
            if (n == 2) rr = (g1l + 1) % 4;
            for (int i = 0; i < 4; i++) begin
                if (acc[i]) begin
                    lq[i].push_back('{a: ain[i], d: din[i]});
                    acc_cnt[i]++;
                end
            end
            e.idle = (n == 0);
            for (int i = 0; i < 4; i++)
                if (lq[i].size() != 0) e.idle = 1'b0;
        end
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        for (int i = 0; i < 4; i++)
            chk($sformatf("ready%0d", i), 32'(rdy[i]),
                32'(!rst && lq[i].size() < 2));
    endtask

    task automatic clear_in();
        for (int i = 0; i < 4; i++) begin
            vin[i] = 1'b0;
            ain[i] = '0;
            din[i] = '0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_in();
        step();
        rst = 1'b0;
    endtask

    // Monitor: compare registered outputs against the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("we0", 32'(we0), 32'(e.we0));
            chk("addr0", 32'(a0), 32'(e.a0));
            chk("data0", d0, e.d0);
            chk("we1", 32'(we1), 32'(e.we1));
            chk("addr1", 32'(a1), 32'(e.a1));
            chk("data1", d1, e.d1);
            chk("idle", 32'(idle), 32'(e.idle));
            if (we0 && we1)
                chk("port_addr_clash", 32'(a0 == a1), 32'd0);
        end
    end

    initial begin
        int budget;
        for (int i = 0; i < 4; i++) acc_cnt[i] = 0;
        rst = 1'b1;
        clear_in();
        step();
        step();
        rst = 1'b0;

        // single request on lane 2
        vin[2] = 1'b1;
        ain[2] = 4'd5;
        din[2] = 32'hDEADBEEF;
        step();
        clear_in();
        step();
        step();
        chk("rr_after_lane2", 32'(rr), 32'd3);

        // four lanes, distinct addresses
        do_reset();
        for (int i = 0; i < 4; i++) begin
            vin[i] = 1'b1;
            ain[i] = 4'(i + 1);
            din[i] = 32'h1000 + 32'(i);
        end
        step();
        clear_in();
        repeat (3) step();
        chk("rr_after_four", 32'(rr), 32'd0);

        // same address on lanes 0 and 1
        do_reset();
        vin[0] = 1'b1;
        ain[0] = 4'd7;
        din[0] = 32'hA0A0;
        vin[1] = 1'b1;
        ain[1] = 4'd7;
        din[1] = 32'hB1B1;
        step();
        clear_in();
        repeat (3) step();

        // lane 3 backpressure while lanes 0-2 stay busy
        do_reset();
        for (int i = 0; i < 4; i++) acc_cnt[i] = 0;
        budget = 0;
        while (acc_cnt[3] < 3 && budget < 40) begin
            for (int i = 0; i < 3; i++) begin
                vin[i] = 1'b1;
                ain[i] = 4'(i + 8);
                din[i] = $urandom;
            end
            vin[3] = 1'b1;
            ain[3] = 4'd12 + 4'(acc_cnt[3]);
            din[3] = 32'h3300 + 32'(acc_cnt[3]);
            step();
            budget++;
        end
        chk("lane3_accepts", 32'(acc_cnt[3]), 32'd3);
        clear_in();
        repeat (8) step();

        // reset with all FIFOs full
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 4; i++) begin
                vin[i] = 1'b1;
                ain[i] = 4'(i * 4 + c);
                din[i] = $urandom;
            end
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        clear_in();
        step();
        chk("idle_after_rst", 32'(idle), 32'd1);

        // randomized traffic with conflicts and occasional resets
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 79) == 0);
            for (int i = 0; i < 4; i++) begin
                vin[i] = 1'($urandom_range(0, 1));
                ain[i] = ($urandom_range(0, 1) == 1) ?
                         4'($urandom_range(0, 3)) :
                         4'($urandom_range(0, 15));
                din[i] = $urandom;
            end
            step();
        end
        rst = 1'b0;
        clear_in();
        repeat (6) step();
        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
